wb_sram_arbiter: RTL and testbench

Two-master Wishbone (pipelined, 32-bit) arbiter placed in front of the 16-bit external SRAM controller, so the ZipCPU data port (master A) and the debug/host bus (master B) can share the one SRAM.
- Grants whole bus cycles (CYC-level ownership) with round-robin fairness on ties.
- Routes ACK/ERR back to the owner only.
- Bounds each owner's outstanding requests.

---
 rtl/wb_arb_pkg.sv | 16 +
 rtl/rr_grant2.sv | 59 +++++
 rtl/wb_sram_arbiter.sv | 134 +++++++++++++
 tb/tb_wb_sram_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone SRAM arbiter:
// owner encoding and the outstanding-request saturation level.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        OWNER_IDLE = 2'b00,
        OWNER_A    = 2'b01,
        OWNER_B    = 2'b10
    } owner_t;

    // Number of outstanding requests at which the owner is held off.
    function automatic int unsigned full_level(input int unsigned lgout);
        return (32'd1 << lgout) - 32'd1;
    endfunction

endpackage

// File: rtl/rr_grant2.sv
// Two-way bus-cycle owner selection with round-robin tie break.
// Ownership is held until the owner's cyc falls, then handed straight over.
module rr_grant2
    import wb_arb_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   req_a,
    input  logic   req_b,
    input  logic   drop,
    output owner_t owner
);

    owner_t owner_q, owner_d;
    logic   last_b_q, last_b_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q  <= OWNER_IDLE;
            last_b_q <= 1'b1;
        end else begin
            owner_q  <= owner_d;
            last_b_q <= last_b_d;
        end
    end

    // last_b only moves when an owner releases, so a tie favours whoever did not just finish.
    always_comb begin
        owner_d  = owner_q;
        last_b_d = last_b_q;
        case (owner_q)
            OWNER_IDLE: begin
                if (req_a && req_b) begin
                    owner_d = last_b_q ? OWNER_A : OWNER_B;
                end else if (req_a) begin
                    owner_d = OWNER_A;
                end else if (req_b) begin
                    owner_d = OWNER_B;
                end
            end
            OWNER_A: begin
                if (drop) begin
                    last_b_d = 1'b0;
                    owner_d  = req_b ? OWNER_B : OWNER_IDLE;
                end
            end
            OWNER_B: begin
                if (drop) begin
                    last_b_d = 1'b1;
                    owner_d  = req_a ? OWNER_A : OWNER_IDLE;
                end
            end
            default: owner_d = OWNER_IDLE;
        endcase
    end

    assign owner = owner_q;

endmodule

// File: rtl/wb_sram_arbiter.sv
// Two-master pipelined Wishbone arbiter in front of the SRAM controller.
// Whole bus cycles are granted; the owner's outstanding requests are bounded.
module wb_sram_arbiter
    import wb_arb_pkg::*;
#(
    parameter int AW               = 15,
    parameter int LGOUT            = 3,
    parameter bit OPT_ZERO_ON_IDLE = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_a_cyc,
    input  logic          i_a_stb,
    input  logic          i_a_we,
    input  logic [AW-1:0] i_a_addr,
    input  logic [31:0]   i_a_data,
    input  logic [3:0]    i_a_sel,
    output logic          o_a_stall,
    output logic          o_a_ack,
    output logic          o_a_err,
    output logic [31:0]   o_a_data,
    input  logic          i_b_cyc,
    input  logic          i_b_stb,
    input  logic          i_b_we,
    input  logic [AW-1:0] i_b_addr,
    input  logic [31:0]   i_b_data,
    input  logic [3:0]    i_b_sel,
    output logic          o_b_stall,
    output logic          o_b_ack,
    output logic          o_b_err,
    output logic [31:0]   o_b_data,
    output logic          o_wb_cyc,
    output logic          o_wb_stb,
    output logic          o_wb_we,
    output logic [AW-1:0] o_wb_addr,
    output logic [31:0]   o_wb_data,
    output logic [3:0]    o_wb_sel,
    input  logic          i_wb_stall,
    input  logic          i_wb_ack,
    input  logic          i_wb_err,
    input  logic [31:0]   i_wb_data,
    output logic [1:0]    o_owner
);

    localparam logic [LGOUT-1:0] FULL_CNT = LGOUT'(full_level(LGOUT));

    owner_t          owner;
    logic            own_a, own_b, drop, full, accept, resp;
    logic            own_cyc, own_stb, own_we;
    logic [AW-1:0]   own_addr;
    logic [31:0]     own_data;
    logic [3:0]      own_sel;
    logic [LGOUT-1:0] cnt;

    assign own_a = (owner == OWNER_A);
    assign own_b = (owner == OWNER_B);
    assign drop  = (own_a && !i_a_cyc) || (own_b && !i_b_cyc);

    rr_grant2 u_grant (
        .clk   (i_clk),
        .rst_n (i_reset_n),
        .req_a (i_a_cyc && i_a_stb),
        .req_b (i_b_cyc && i_b_stb),
        .drop  (drop),
        .owner (owner)
    );

    always_comb begin
        own_cyc  = 1'b0;
        own_stb  = 1'b0;
        own_we   = OPT_ZERO_ON_IDLE ? 1'b0 : i_a_we;
        own_addr = OPT_ZERO_ON_IDLE ? '0 : i_a_addr;
        own_data = OPT_ZERO_ON_IDLE ? '0 : i_a_data;
        own_sel  = OPT_ZERO_ON_IDLE ? '0 : i_a_sel;
        case (owner)
            OWNER_A: begin
                own_cyc  = i_a_cyc;
                own_stb  = i_a_stb;
                own_we   = i_a_we;
                own_addr = i_a_addr;
                own_data = i_a_data;
                own_sel  = i_a_sel;
            end
            OWNER_B: begin
                own_cyc  = i_b_cyc;
                own_stb  = i_b_stb;
                own_we   = i_b_we;
                own_addr = i_b_addr;
                own_data = i_b_data;
                own_sel  = i_b_sel;
            end
            default: begin
            end
        endcase
    end

    assign full      = (cnt == FULL_CNT);
    assign o_wb_cyc  = own_cyc;
    assign o_wb_stb  = own_cyc && own_stb && !full;
    assign o_wb_we   = own_we;
    assign o_wb_addr = own_addr;
    assign o_wb_data = own_data;
    assign o_wb_sel  = own_sel;
    assign o_owner   = owner;

    assign accept = o_wb_stb && !i_wb_stall;
    assign resp   = (i_wb_ack || i_wb_err) && (cnt != '0);

    // Releasing cyc abandons anything still in flight, so the count restarts.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt <= '0;
        end else if (drop) begin
            cnt <= '0;
        end else if (accept && !resp) begin
            cnt <= cnt + LGOUT'(1);
        end else if (!accept && resp) begin
            cnt <= cnt - LGOUT'(1);
        end
    end

    assign o_a_stall = !own_a || i_wb_stall || full;
    assign o_b_stall = !own_b || i_wb_stall || full;
    assign o_a_ack   = i_wb_ack && own_a && i_a_cyc;
    assign o_b_ack   = i_wb_ack && own_b && i_b_cyc;
    assign o_a_err   = i_wb_err && own_a && i_a_cyc;
    assign o_b_err   = i_wb_err && own_b && i_b_cyc;
    assign o_a_data  = i_wb_data;
    assign o_b_data  = i_wb_data;

    ack_needs_outstanding: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        (o_wb_cyc && (i_wb_ack || i_wb_err)) |-> (cnt != '0));

endmodule

// File: tb/tb_wb_sram_arbiter.sv
// Bench for wb_sram_arbiter: directed scenarios with literal expectations,
// then random traffic, all outputs compared each cycle to a reference model.
module tb_wb_sram_arbiter;

    localparam int AW    = 15;
    localparam int LGOUT = 2;
    localparam int FULL  = (1 << LGOUT) - 1;

    logic          i_clk = 1'b0;
    logic          i_reset_n = 1'b1;
    logic          i_a_cyc = 0, i_a_stb = 0, i_a_we = 0;
    logic [AW-1:0] i_a_addr = '0;
    logic [31:0]   i_a_data = '0;
    logic [3:0]    i_a_sel = '0;
    logic          i_b_cyc = 0, i_b_stb = 0, i_b_we = 0;
    logic [AW-1:0] i_b_addr = '0;
    logic [31:0]   i_b_data = '0;
    logic [3:0]    i_b_sel = '0;
    logic          i_wb_stall = 0, i_wb_ack = 0, i_wb_err = 0;
    logic [31:0]   i_wb_data = '0;
    logic          o_a_stall, o_a_ack, o_a_err, o_b_stall, o_b_ack, o_b_err;
    logic [31:0]   o_a_data, o_b_data, o_wb_data;
    logic          o_wb_cyc, o_wb_stb, o_wb_we;
    logic [AW-1:0] o_wb_addr;
    logic [3:0]    o_wb_sel;
    logic [1:0]    o_owner;

    wb_sram_arbiter #(.AW(AW), .LGOUT(LGOUT), .OPT_ZERO_ON_IDLE(1'b1)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_a_cyc(i_a_cyc), .i_a_stb(i_a_stb), .i_a_we(i_a_we), .i_a_addr(i_a_addr),
        .i_a_data(i_a_data), .i_a_sel(i_a_sel), .o_a_stall(o_a_stall), .o_a_ack(o_a_ack),
        .o_a_err(o_a_err), .o_a_data(o_a_data),
        .i_b_cyc(i_b_cyc), .i_b_stb(i_b_stb), .i_b_we(i_b_we), .i_b_addr(i_b_addr),
        .i_b_data(i_b_data), .i_b_sel(i_b_sel), .o_b_stall(o_b_stall), .o_b_ack(o_b_ack),
        .o_b_err(o_b_err), .o_b_data(o_b_data),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
        .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel), .i_wb_stall(i_wb_stall),
        .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .i_wb_data(i_wb_data), .o_owner(o_owner)
    );

    initial forever #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    int pend = 0;
    int m_owner = 0;
    int m_last = 2;
    int m_cnt = 0;

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: owner 0 idle, 1 A, 2 B; outputs derived from the arbitration rules.
    task automatic compare_cycle();
        logic        cyc[3], stb[3], we[3];
        logic [31:0] addr[3], data[3], sel[3];
        logic        full, e_cyc, e_stb, rsp;
        int          o, other, acc, dec;
        if (!i_reset_n) begin
            m_owner = 0;
            m_last  = 2;
            m_cnt   = 0;
        end
        cyc[0] = 0; stb[0] = 0; we[0] = 0; addr[0] = 0; data[0] = 0; sel[0] = 0;
        cyc[1] = i_a_cyc; stb[1] = i_a_stb; we[1] = i_a_we;
        addr[1] = 32'(i_a_addr); data[1] = i_a_data; sel[1] = 32'(i_a_sel);
        cyc[2] = i_b_cyc; stb[2] = i_b_stb; we[2] = i_b_we;
        addr[2] = 32'(i_b_addr); data[2] = i_b_data; sel[2] = 32'(i_b_sel);
        o     = m_owner;
        full  = (m_cnt == FULL);
        e_cyc = cyc[o];
        e_stb = e_cyc && stb[o] && !full;
        rsp   = i_wb_ack || i_wb_err;
        check_output("owner", 32'(o_owner), 32'(o));
        check_output("wb_cyc", 32'(o_wb_cyc), 32'(e_cyc));
        check_output("wb_stb", 32'(o_wb_stb), 32'(e_stb));
        check_output("wb_we", 32'(o_wb_we), 32'(we[o]));
        check_output("wb_addr", 32'(o_wb_addr), addr[o]);
        check_output("wb_data", o_wb_data, data[o]);
        check_output("wb_sel", 32'(o_wb_sel), sel[o]);
        check_output("a_stall", 32'(o_a_stall), 32'((o != 1) || i_wb_stall || full));
        check_output("b_stall", 32'(o_b_stall), 32'((o != 2) || i_wb_stall || full));
        check_output("a_ack", 32'(o_a_ack), 32'(i_wb_ack && o == 1 && cyc[1]));
        check_output("b_ack", 32'(o_b_ack), 32'(i_wb_ack && o == 2 && cyc[2]));
        check_output("a_err", 32'(o_a_err), 32'(i_wb_err && o == 1 && cyc[1]));
        check_output("b_err", 32'(o_b_err), 32'(i_wb_err && o == 2 && cyc[2]));
        check_output("a_data", o_a_data, i_wb_data);
        check_output("b_data", o_b_data, i_wb_data);
        if (i_reset_n) begin
            if (o == 0) begin
                if (cyc[1] && stb[1] && cyc[2] && stb[2]) m_owner = (m_last == 1) ? 2 : 1;
                else if (cyc[1] && stb[1]) m_owner = 1;
                else if (cyc[2] && stb[2]) m_owner = 2;
            end else if (!cyc[o]) begin
                other   = 3 - o;
                m_last  = o;
                m_cnt   = 0;
                m_owner = (cyc[other] && stb[other]) ? other : 0;
            end else begin
                acc   = (e_stb && !i_wb_stall) ? 1 : 0;
                dec   = (rsp && m_cnt > 0) ? 1 : 0;
                m_cnt = m_cnt + acc - dec;
            end
        end
    endtask

    initial forever begin
        @(negedge i_clk);
        compare_cycle();
    end

    // Outstanding requests as the SRAM sees them; lost whenever cyc is low.
    initial forever begin
        @(negedge i_clk);
        if (!o_wb_cyc) pend = 0;
        else pend = pend + int'(o_wb_stb && !i_wb_stall) - int'(i_wb_ack || i_wb_err);
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_a_cyc = 0; i_a_stb = 0; i_a_we = 0; i_a_addr = '0; i_a_data = '0; i_a_sel = '0;
        i_b_cyc = 0; i_b_stb = 0; i_b_we = 0; i_b_addr = '0; i_b_data = '0; i_b_sel = '0;
        i_wb_stall = 0; i_wb_ack = 0; i_wb_err = 0; i_wb_data = '0;
    endtask

    task automatic apply_stimulus();
        tick();
        i_a_cyc  = i_a_cyc ? ($urandom % 8 != 0) : ($urandom % 3 == 0);
        i_a_stb  = i_a_cyc ? ($urandom % 2 == 0) : ($urandom % 10 == 0);
        i_a_we   = ($urandom % 2 == 0);
        i_a_addr = AW'($urandom);
        i_a_data = $urandom;
        i_a_sel  = 4'($urandom);
        i_b_cyc  = i_b_cyc ? ($urandom % 8 != 0) : ($urandom % 3 == 0);
        i_b_stb  = i_b_cyc ? ($urandom % 2 == 0) : ($urandom % 10 == 0);
        i_b_we   = ($urandom % 2 == 0);
        i_b_addr = AW'($urandom);
        i_b_data = $urandom;
        i_b_sel  = 4'($urandom);
        i_wb_stall = ($urandom % 4 == 0);
        i_wb_data  = $urandom;
        i_wb_ack   = 0;
        i_wb_err   = 0;
        #1;
        if (o_wb_cyc && pend > 0 && $urandom % 3 == 0) begin
            if ($urandom % 8 == 0) i_wb_err = 1;
            else i_wb_ack = 1;
        end
    endtask

    initial begin
        int accepted;
        #1 i_reset_n = 0;
        #1;
        check_output("rst_owner", 32'(o_owner), 32'h0);
        check_output("rst_wb_cyc", 32'(o_wb_cyc), 32'h0);
        check_output("rst_a_stall", 32'(o_a_stall), 32'h1);
        repeat (2) tick();
        i_reset_n = 1;

        // Single read from A
        tick();
        i_a_cyc = 1; i_a_stb = 1; i_a_addr = 15'h0010; i_a_sel = 4'hF;
        #1;
        check_output("rd_arb_owner", 32'(o_owner), 32'h0);
        check_output("rd_arb_stall", 32'(o_a_stall), 32'h1);
        tick(); #1;
        check_output("rd_owner", 32'(o_owner), 32'h1);
        check_output("rd_stb", 32'(o_wb_stb), 32'h1);
        check_output("rd_addr", 32'(o_wb_addr), 32'h10);
        tick();
        i_a_stb = 0;
        repeat (6) tick();
        i_wb_ack = 1; i_wb_data = 32'hDEADBEEF;
        #1;
        check_output("rd_a_ack", 32'(o_a_ack), 32'h1);
        check_output("rd_a_data", o_a_data, 32'hDEADBEEF);
        check_output("rd_b_ack", 32'(o_b_ack), 32'h0);
        tick();
        i_wb_ack = 0; i_a_cyc = 0;
        #1;
        check_output("rd_drop_cyc", 32'(o_wb_cyc), 32'h0);
        tick(); #1;
        check_output("rd_idle", 32'(o_owner), 32'h0);

        // Tie after reset, handoff without an idle cycle
        i_reset_n = 0;
        tick();
        i_reset_n = 1;
        tick();
        i_a_cyc = 1; i_a_stb = 1; i_b_cyc = 1; i_b_stb = 1; i_b_addr = 15'h0020;
        #1;
        check_output("tie_arb_owner", 32'(o_owner), 32'h0);
        tick(); #1;
        check_output("tie_owner_a", 32'(o_owner), 32'h1);
        check_output("tie_b_stall", 32'(o_b_stall), 32'h1);
        tick();
        i_a_stb = 0; i_wb_ack = 1;
        #1;
        check_output("tie_a_ack", 32'(o_a_ack), 32'h1);
        check_output("tie_b_noack", 32'(o_b_ack), 32'h0);
        tick();
        i_wb_ack = 0; i_a_cyc = 0;
        #1;
        check_output("tie_drop_owner", 32'(o_owner), 32'h1);
        tick(); #1;
        check_output("tie_owner_b", 32'(o_owner), 32'h2);
        check_output("tie_b_go", 32'(o_b_stall), 32'h0);
        tick();
        i_b_stb = 0; i_wb_ack = 1;
        #1;
        check_output("tie_b_ack", 32'(o_b_ack), 32'h1);
        check_output("tie_a_noack", 32'(o_a_ack), 32'h0);
        tick();
        i_wb_ack = 0; i_b_cyc = 0;
        tick();
        i_a_cyc = 1; i_a_stb = 1; i_b_cyc = 1; i_b_stb = 1;
        #1;
        check_output("tie2_idle", 32'(o_owner), 32'h0);
        tick(); #1;
        check_output("tie2_owner_a", 32'(o_owner), 32'h1);
        tick();
        i_a_cyc = 0; i_a_stb = 0;
        tick(); #1;
        check_output("tie2_owner_b", 32'(o_owner), 32'h2);
        tick();
        i_b_cyc = 0; i_b_stb = 0;
        tick(); #1;
        check_output("tie2_idle_end", 32'(o_owner), 32'h0);

        // A holds the bus for three writes while B keeps requesting
        i_a_cyc = 1; i_a_stb = 1; i_a_we = 1; i_a_addr = 15'h1; i_a_data = 32'h11111111; i_a_sel = 4'hF;
        i_b_cyc = 1; i_b_stb = 1;
        tick(); #1;
        check_output("hold_owner_a", 32'(o_owner), 32'h1);
        check_output("hold_sel_f", 32'(o_wb_sel), 32'hF);
        check_output("hold_we", 32'(o_wb_we), 32'h1);
        check_output("hold_b_stall1", 32'(o_b_stall), 32'h1);
        tick();
        i_a_addr = 15'h2; i_a_data = 32'h22222222; i_a_sel = 4'h3; i_wb_ack = 1;
        #1;
        check_output("hold_sel_3", 32'(o_wb_sel), 32'h3);
        check_output("hold_addr_2", 32'(o_wb_addr), 32'h2);
        check_output("hold_b_stall2", 32'(o_b_stall), 32'h1);
        tick();
        i_a_addr = 15'h3; i_a_data = 32'h33333333; i_a_sel = 4'hC;
        #1;
        check_output("hold_sel_c", 32'(o_wb_sel), 32'hC);
        check_output("hold_b_stall3", 32'(o_b_stall), 32'h1);
        tick();
        i_a_stb = 0;
        #1;
        check_output("hold_no_stb", 32'(o_wb_stb), 32'h0);
        tick();
        i_wb_ack = 0; i_a_cyc = 0; i_a_we = 0;
        #1;
        check_output("hold_drop_owner", 32'(o_owner), 32'h1);
        check_output("hold_b_stall4", 32'(o_b_stall), 32'h1);
        tick(); #1;
        check_output("hold_owner_b", 32'(o_owner), 32'h2);
        check_output("hold_b_go", 32'(o_b_stall), 32'h0);
        tick();
        i_b_cyc = 0; i_b_stb = 0;
        tick();

        // Saturation at 2^LGOUT-1 outstanding, then abort with two in flight
        i_a_cyc = 1; i_a_stb = 1; i_a_addr = 15'h5;
        accepted = 0;
        for (int i = 0; i < 5; i++) begin
            tick(); #1;
            if (o_wb_stb && !i_wb_stall) accepted++;
        end
        check_output("sat_accepted", 32'(accepted), 32'd3);
        check_output("sat_stall", 32'(o_a_stall), 32'h1);
        i_wb_ack = 1;
        #1;
        check_output("sat_stall_ack", 32'(o_a_stall), 32'h1);
        tick();
        i_wb_ack = 0;
        #1;
        check_output("sat_fourth_go", 32'(o_a_stall), 32'h0);
        check_output("sat_fourth_stb", 32'(o_wb_stb), 32'h1);
        tick(); #1;
        check_output("sat_full_again", 32'(o_a_stall), 32'h1);
        i_a_stb = 0; i_wb_ack = 1;
        tick();
        i_wb_ack = 0; i_a_cyc = 0;
        #1;
        check_output("abort_cyc", 32'(o_wb_cyc), 32'h0);
        tick();
        i_wb_ack = 1;
        #1;
        check_output("abort_a_ack", 32'(o_a_ack), 32'h0);
        check_output("abort_b_ack", 32'(o_b_ack), 32'h0);
        tick();
        i_wb_ack = 0; i_a_cyc = 1; i_a_stb = 1;
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            check_output("abort_cnt_clear", 32'(o_a_stall), 32'h0);
            tick();
        end
        #1;
        check_output("abort_refull", 32'(o_a_stall), 32'h1);
        i_a_cyc = 0; i_a_stb = 0;
        tick();
        tick();

        // Asynchronous reset while B owns the bus with one request in flight
        i_b_cyc = 1; i_b_stb = 1; i_b_addr = 15'h0030;
        tick(); #1;
        check_output("rst_owner_b", 32'(o_owner), 32'h2);
        tick();
        i_b_stb = 0;
        #1;
        i_reset_n = 0;
        #1;
        check_output("rst_mid_cyc", 32'(o_wb_cyc), 32'h0);
        check_output("rst_mid_owner", 32'(o_owner), 32'h0);
        tick();
        i_a_cyc = 1; i_a_stb = 1; i_b_stb = 1;
        tick();
        i_reset_n = 1;
        #1;
        check_output("rst_rel_idle", 32'(o_owner), 32'h0);
        tick(); #1;
        check_output("rst_tie_a", 32'(o_owner), 32'h1);
        idle_inputs();
        tick();
        tick();

        // Random traffic against the reference model
        for (int i = 0; i < 3000; i++) apply_stimulus();
        tick();
        idle_inputs();
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
